// File: rtl/rx_serial_7n2_if.sv
// Signal bundle between the 7N2 serial receiver and its consumer.
// The receiver connects through the master modport; the consumer or line driver uses slave.
interface rx_serial_7n2_if;
  logic       entrada_serial;
  logic [6:0] dados_ascii;
  logic       pronto;
  logic       erro;
  logic       ocupado;
  logic [3:0] db_estado;

  modport master (
    input  entrada_serial,
    output dados_ascii,
    output pronto,
    output erro,
    output ocupado,
    output db_estado
  );

  modport slave (
    output entrada_serial,
    input  dados_ascii,
    input  pronto,
    input  erro,
    input  ocupado,
    input  db_estado
  );
endinterface

// File: rtl/rx_serial_7n2.sv
// 7N2 asynchronous serial receiver: mid-bit sampling, 7 data bits LSB first, two stop bits.
// Optional input synchronizer: define RX_SERIAL_7N2_SYNC_EN (adds 2 cycles of latency).
//
// state   | meaning
// REPOUSO | idle, waiting for the line to fall
// INICIO  | half-bit wait, then start bit confirmation
// DADOS   | sampling 7 data bits at bit centre
// PARADA1 | sampling first stop bit
// PARADA2 | sampling second stop bit
// FIM     | good frame, pronto pulse
// ERRO    | bad stop bit, erro pulse
// ESPERA  | line stuck low after an error, wait for idle
module rx_serial_7n2 #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic            clock,
  input  logic            reset,
  rx_serial_7n2_if.master bus
);

  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int BW   = $clog2(CLKS_PER_BIT);

  localparam logic [BW-1:0] HALF_M1 = BW'(HALF - 1);
  localparam logic [BW-1:0] BIT_M1  = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [3:0] {
    REPOUSO = 4'd0,
    INICIO  = 4'd1,
    DADOS   = 4'd2,
    PARADA1 = 4'd3,
    PARADA2 = 4'd4,
    FIM     = 4'd5,
    ERRO    = 4'd6,
    ESPERA  = 4'd7
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [BW-1:0]   r_baud;
  logic [3:0]      r_bitcnt;
  logic [6:0]      r_shift;
  logic [6:0]      r_dados;
  logic            r_stop_err;
  logic            w_rx;
  logic            w_half_tick;
  logic            w_bit_tick;
  logic            w_frame_ok;
  logic            w_pronto;
  logic            w_erro;
  logic            w_ocupado;

`ifdef RX_SERIAL_7N2_SYNC_EN
  logic [1:0] r_sync;

  // Flops reset to the idle level so a reset never looks like a start bit.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sync <= 2'b11;
    end else begin
      r_sync <= {r_sync[0], bus.entrada_serial};
    end
  end

  assign w_rx = r_sync[1];
`else
  assign w_rx = bus.entrada_serial;
`endif

  assign w_half_tick = (r_baud == HALF_M1);
  assign w_bit_tick  = (r_baud == BIT_M1);
  assign w_frame_ok  = !r_stop_err && w_rx;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= REPOUSO;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      REPOUSO: if (!w_rx) w_next = INICIO;
      INICIO:  if (w_half_tick) w_next = w_rx ? REPOUSO : DADOS;
      DADOS:   if (w_bit_tick && (r_bitcnt == 4'd6)) w_next = PARADA1;
      PARADA1: if (w_bit_tick) w_next = PARADA2;
      PARADA2: if (w_bit_tick) w_next = w_frame_ok ? FIM : ERRO;
      FIM:     w_next = REPOUSO;
      ERRO:    w_next = w_rx ? REPOUSO : ESPERA;
      ESPERA:  if (w_rx) w_next = REPOUSO;
      default: w_next = REPOUSO;
    endcase
  end

  always_comb begin
    w_pronto  = 1'b0;
    w_erro    = 1'b0;
    w_ocupado = 1'b1;
    case (r_state)
      REPOUSO: w_ocupado = 1'b0;
      FIM:     w_pronto  = 1'b1;
      ERRO:    w_erro    = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_baud     <= '0;
      r_bitcnt   <= 4'd0;
      r_shift    <= 7'h00;
      r_stop_err <= 1'b0;
    end else begin
      case (r_state)
        INICIO: begin
          r_baud     <= w_half_tick ? '0 : r_baud + BW'(1);
          r_bitcnt   <= 4'd0;
          r_stop_err <= 1'b0;
        end
        DADOS: begin
          r_baud <= w_bit_tick ? '0 : r_baud + BW'(1);
          if (w_bit_tick) begin
            r_shift  <= {w_rx, r_shift[6:1]};
            r_bitcnt <= r_bitcnt + 4'd1;
          end
        end
        PARADA1: begin
          r_baud <= w_bit_tick ? '0 : r_baud + BW'(1);
          if (w_bit_tick && !w_rx) r_stop_err <= 1'b1;
        end
        PARADA2: begin
          r_baud <= w_bit_tick ? '0 : r_baud + BW'(1);
        end
        default: begin
          r_baud <= '0;
        end
      endcase
    end
  end

  // Loaded on the edge that enters FIM so the character is valid alongside pronto.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_dados <= 7'h00;
    end else if ((r_state == PARADA2) && w_bit_tick && w_frame_ok) begin
      r_dados <= r_shift;
    end
  end

  assign bus.dados_ascii = r_dados;
  assign bus.pronto      = w_pronto;
  assign bus.erro        = w_erro;
  assign bus.ocupado     = w_ocupado;
  assign bus.db_estado   = r_state;

endmodule
